loader_responder: RTL and testbench

- Host-side end of the UART program-load protocol; the CPU-side loader is the initiator.
- Waits for the 0x99 sync byte, then streams a 32-bit program size, the program words and, after the 0xaa acknowledge, the data words.
- Image words come from a synchronous-read image memory.
- Sits between a UART receiver/sender pair and an image ROM. Used for on-FPGA loopback bring-up and as a synthesizable bench model of the server.

---
 rtl/loader_responder.sv | 168 ++++++++++++++++
 tb/tb_loader_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loader_responder.sv
// Host-side UART program-load responder: answers the 0x99 sync with the
// program size, program words and, after the 0xaa ack, the data words.
module loader_responder #(
  parameter int PROG_WORDS = 16,
  parameter int DATA_WORDS = 4,
  parameter int AW         = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx_ready,
  input  logic [7:0]    rdata,
  input  logic          tx_busy,
  output logic          tx_start,
  output logic [7:0]    sdata,
  output logic [AW-1:0] img_addr,
  input  logic [31:0]   img_word,
  output logic          done,
  output logic          proto_err
);

  typedef enum logic [2:0] {
    WAIT_SYNC,
    SEND_SIZE,
    FETCH_PROG,
    SEND_PROG,
    WAIT_ACK,
    FETCH_DATA,
    SEND_DATA,
    DONE_S
  } state_t;

  localparam logic [31:0]   SIZE   = 32'(PROG_WORDS * 4);
  localparam logic [AW-1:0] LAST_P = AW'(PROG_WORDS - 1);
  localparam logic [AW-1:0] BASE_D = AW'(PROG_WORDS);
  localparam logic [AW-1:0] LAST_D = AW'(PROG_WORDS + DATA_WORDS - 1);

  state_t        r_state, w_state;
  logic [1:0]    r_idx, w_idx;
  logic [AW-1:0] r_addr, w_addr;
  logic [31:0]   r_sh, w_sh;
  logic [1:0]    r_hold, w_hold;
  logic          r_wait, w_wait;
  logic          r_err, w_err;
  logic          w_can;
  logic          w_last;
  logic [31:0]   w_size_sh;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= WAIT_SYNC;
      r_idx   <= '0;
      r_addr  <= '0;
      r_sh    <= '0;
      r_hold  <= '0;
      r_wait  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_addr  <= w_addr;
      r_sh    <= w_sh;
      r_hold  <= w_hold;
      r_wait  <= w_wait;
      r_err   <= w_err;
    end
  end

  assign w_can     = !tx_busy && (r_hold == 2'd0);
  assign w_size_sh = SIZE << {r_idx, 3'b000};
  assign w_last    = (r_state == SEND_PROG) ? (r_addr == LAST_P)
                                            : (r_addr == LAST_D);

  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_addr   = r_addr;
    w_sh     = r_sh;
    w_hold   = (r_hold != 2'd0) ? r_hold - 2'd1 : 2'd0;
    w_wait   = r_wait;
    w_err    = r_err;
    tx_start = 1'b0;
    sdata    = 8'h00;
    unique case (r_state)
      WAIT_SYNC: begin
        if (rx_ready) begin
          if (rdata == 8'h99) begin
            w_state = SEND_SIZE;
            w_idx   = 2'd0;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      SEND_SIZE: begin
        if (rx_ready) w_err = 1'b1;
        if (w_can) begin
          tx_start = 1'b1;
          sdata    = w_size_sh[31:24];
          w_hold   = 2'd2;
          w_idx    = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            if (PROG_WORDS == 0) begin
              w_state = WAIT_ACK;
            end else begin
              w_state = FETCH_PROG;
              w_addr  = '0;
              w_wait  = 1'b1;
            end
          end
        end
      end
      // first cycle lets the ROM see the new address, second latches it
      FETCH_PROG, FETCH_DATA: begin
        if (rx_ready) w_err = 1'b1;
        if (r_wait) begin
          w_wait = 1'b0;
        end else begin
          w_sh    = img_word;
          w_idx   = 2'd0;
          w_state = (r_state == FETCH_PROG) ? SEND_PROG : SEND_DATA;
        end
      end
      SEND_PROG, SEND_DATA: begin
        if (rx_ready) w_err = 1'b1;
        if (w_can) begin
          tx_start = 1'b1;
          sdata    = r_sh[31:24];
          w_sh     = {r_sh[23:0], 8'h00};
          w_hold   = 2'd2;
          w_idx    = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            if (w_last) begin
              w_state = (r_state == SEND_PROG) ? WAIT_ACK : DONE_S;
            end else begin
              w_addr  = r_addr + 1'b1;
              w_wait  = 1'b1;
              w_state = (r_state == SEND_PROG) ? FETCH_PROG : FETCH_DATA;
            end
          end
        end
      end
      WAIT_ACK: begin
        if (rx_ready) begin
          if (rdata == 8'haa) begin
            if (DATA_WORDS == 0) begin
              w_state = DONE_S;
            end else begin
              w_state = FETCH_DATA;
              w_addr  = BASE_D;
              w_wait  = 1'b1;
            end
          end else begin
            w_err = 1'b1;
          end
        end
      end
      DONE_S: begin
        if (rx_ready) w_err = 1'b1;
      end
      default: w_state = WAIT_SYNC;
    endcase
  end

  assign img_addr  = r_addr;
  assign done      = (r_state == DONE_S);
  assign proto_err = r_err;

endmodule

// File: tb/tb_loader_responder.sv
// Scoreboard bench for loader_responder: a 2+1 word image instance and an
// empty-image instance, each with its own sender model and byte monitor.
module tb_loader_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        force_busy = 1'b0;

  logic        a_rx_ready = 1'b0;
  logic [7:0]  a_rdata = 8'h00;
  logic        a_tx_busy;
  logic        a_tx_start;
  logic [7:0]  a_sdata;
  logic [15:0] a_img_addr;
  logic [31:0] a_img_word = 32'h0;
  logic        a_done;
  logic        a_proto_err;

  logic        b_rx_ready = 1'b0;
  logic [7:0]  b_rdata = 8'h00;
  logic        b_tx_busy;
  logic        b_tx_start;
  logic [7:0]  b_sdata;
  logic [15:0] b_img_addr;
  logic [31:0] b_img_word = 32'h0;
  logic        b_done;
  logic        b_proto_err;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int a_cnt = 0;
  int b_cnt = 0;
  int a_last = -10;
  int a_bcnt = 0;
  int b_bcnt = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  logic [31:0] rom [3] = '{32'h11223344, 32'ha5a50f0f, 32'hdeadbeef};
  logic [7:0]  a_exp [16] = '{8'h00, 8'h00, 8'h00, 8'h08,
                              8'h11, 8'h22, 8'h33, 8'h44,
                              8'ha5, 8'ha5, 8'h0f, 8'h0f,
                              8'hde, 8'had, 8'hbe, 8'hef};

  loader_responder #(.PROG_WORDS(2), .DATA_WORDS(1), .AW(16)) u_a (
    .clock    (clock),
    .reset    (reset),
    .rx_ready (a_rx_ready),
    .rdata    (a_rdata),
    .tx_busy  (a_tx_busy),
    .tx_start (a_tx_start),
    .sdata    (a_sdata),
    .img_addr (a_img_addr),
    .img_word (a_img_word),
    .done     (a_done),
    .proto_err(a_proto_err)
  );

  loader_responder #(.PROG_WORDS(0), .DATA_WORDS(0), .AW(16)) u_b (
    .clock    (clock),
    .reset    (reset),
    .rx_ready (b_rx_ready),
    .rdata    (b_rdata),
    .tx_busy  (b_tx_busy),
    .tx_start (b_tx_start),
    .sdata    (b_sdata),
    .img_addr (b_img_addr),
    .img_word (b_img_word),
    .done     (b_done),
    .proto_err(b_proto_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    a_img_word <= (a_img_addr < 16'd3) ? rom[a_img_addr[1:0]] : 32'h0;
    if (a_tx_start) a_bcnt <= 10;
    else if (a_bcnt != 0) a_bcnt <= a_bcnt - 1;
    if (b_tx_start) b_bcnt <= 10;
    else if (b_bcnt != 0) b_bcnt <= b_bcnt - 1;
  end

  assign a_tx_busy = (a_bcnt != 0) || force_busy;
  assign b_tx_busy = (b_bcnt != 0);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clock) begin
    if (a_tx_start) begin
      a_cnt++;
      chk("a_gap_ge3", 32'((cyc - a_last) >= 3), 32'd1);
      a_last = cyc;
      if (qa.size() == 0) chk("a_unexpected_byte", {24'h0, a_sdata}, 32'hffffffff);
      else chk("a_sdata", {24'h0, a_sdata}, {24'h0, qa.pop_front()});
    end
    if (b_tx_start) begin
      b_cnt++;
      if (qb.size() == 0) chk("b_unexpected_byte", {24'h0, b_sdata}, 32'hffffffff);
      else chk("b_sdata", {24'h0, b_sdata}, {24'h0, qb.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    a_rx_ready = 1'b1;
    a_rdata = b;
    tick(1);
    a_rx_ready = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    b_rx_ready = 1'b1;
    b_rdata = b;
    tick(1);
    b_rx_ready = 1'b0;
  endtask

  task automatic wait_a(input int n, input int lim);
    int k = 0;
    while (a_cnt < n && k < lim) begin
      tick(1);
      k++;
    end
    chk("a_reach_count", 32'(a_cnt >= n), 32'd1);
  endtask

  task automatic push_a();
    for (int i = 0; i < 16; i++) qa.push_back(a_exp[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    qa.delete();
    qb.delete();
    a_cnt = 0;
    b_cnt = 0;
  endtask

  task automatic finish_a(input logic exp_err);
    wait_a(12, 600);
    tick(3);
    chk("a_done_before_ack", {31'h0, a_done}, 32'd0);
    send_a(8'haa);
    wait_a(16, 400);
    tick(2);
    chk("a_done", {31'h0, a_done}, 32'd1);
    chk("a_proto_err", {31'h0, a_proto_err}, {31'h0, exp_err});
    chk("a_queue_empty", qa.size(), 32'd0);
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    chk("rst_tx_start", {31'h0, a_tx_start}, 32'd0);
    chk("rst_sdata", {24'h0, a_sdata}, 32'd0);
    chk("rst_img_addr", {16'h0, a_img_addr}, 32'd0);
    chk("rst_done", {31'h0, a_done}, 32'd0);
    chk("rst_proto_err", {31'h0, a_proto_err}, 32'd0);

    // normal transfer
    push_a();
    send_a(8'h99);
    finish_a(1'b0);

    // junk before sync
    do_reset();
    send_a(8'h55);
    tick(20);
    chk("junk_proto_err", {31'h0, a_proto_err}, 32'd1);
    chk("junk_no_tx", a_cnt, 32'd0);
    push_a();
    send_a(8'h99);
    finish_a(1'b1);

    // sender stalls after second size byte
    do_reset();
    push_a();
    send_a(8'h99);
    wait_a(2, 100);
    force_busy = 1'b1;
    tick(100);
    chk("busy_no_tx", a_cnt, 32'd2);
    force_busy = 1'b0;
    tick(1);
    chk("busy_resume", a_cnt, 32'd3);
    finish_a(1'b0);

    // reset in the middle of the first program word
    do_reset();
    push_a();
    send_a(8'h99);
    wait_a(6, 200);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_tx_start", {31'h0, a_tx_start}, 32'd0);
    chk("mid_sdata", {24'h0, a_sdata}, 32'd0);
    chk("mid_img_addr", {16'h0, a_img_addr}, 32'd0);
    chk("mid_done", {31'h0, a_done}, 32'd0);
    chk("mid_proto_err", {31'h0, a_proto_err}, 32'd0);
    qa.delete();
    a_cnt = 0;
    tick(20);
    chk("mid_no_tx", a_cnt, 32'd0);
    push_a();
    send_a(8'h99);
    finish_a(1'b0);

    // stray sync byte while sending program
    do_reset();
    push_a();
    send_a(8'h99);
    wait_a(5, 200);
    send_a(8'h99);
    tick(1);
    chk("stray_proto_err", {31'h0, a_proto_err}, 32'd1);
    finish_a(1'b1);

    // empty image
    do_reset();
    for (int i = 0; i < 4; i++) qb.push_back(8'h00);
    send_b(8'h99);
    for (int k = 0; k < 100 && b_cnt < 4; k++) tick(1);
    chk("b_reach_count", b_cnt, 32'd4);
    tick(5);
    chk("b_done_before_ack", {31'h0, b_done}, 32'd0);
    send_b(8'haa);
    tick(2);
    chk("b_done", {31'h0, b_done}, 32'd1);
    chk("b_img_addr", {16'h0, b_img_addr}, 32'd0);
    chk("b_proto_err", {31'h0, b_proto_err}, 32'd0);
    chk("b_queue_empty", qb.size(), 32'd0);
    tick(20);
    chk("b_no_extra_tx", b_cnt, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
